io_dma: RTL and testbench

Stream buffer-and-replay block at the input of the accelerator datapath. It accepts one frame of signed 20-bit words over an AXI4-Stream slave, for example a 28×28 pixel image plus 2 header words (786 words). It stores the frame internally, then replays it on a 32-bit AXI4-Stream master, sign-extended, followed by a 32-bit checksum word. It isolates the upstream word source (BRAM/DMA) from downstream compute.

---
 rtl/io_dma_if.sv | 12 +
 rtl/io_dma.sv | 105 ++++++++++
 tb/tb_io_dma.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_dma_if.sv
// AXI4-Stream style word channel used for both the input and the output side of io_dma.
interface io_dma_if #(
    parameter int WIDTH = 20
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/io_dma.sv
// Frame buffer-and-replay: stores one input frame of signed words, then replays it
// sign-extended on the output stream followed by a checksum word carrying tlast.
module io_dma #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 1024
) (
    input  logic     aclk,
    input  logic     aresetn,
    io_dma_if.slave  s_axis,
    io_dma_if.master m_axis
);
    // state  | meaning
    // S_INIT | first cycle after reset, no handshakes
    // S_RECV | accept input words, store and sum the first DEPTH of them
    // S_LOAD | RAM read of word 0 in flight, output not yet valid
    // S_SEND | replay buffer[0..count-1]
    // S_SUM  | present checksum word with tlast

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_INIT, S_RECV, S_LOAD, S_SEND, S_SUM} state_t;

    state_t               state, state_nxt;
    logic [IN_WIDTH-1:0]  mem [DEPTH];
    logic [IN_WIDTH-1:0]  rd_q;
    logic [AW-1:0]        rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]        count;
    logic [OUT_WIDTH-1:0] sum;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 in_fire, out_fire, store, last_word;

    // Outputs are gated by reset so they read idle while reset is held, not just after.
    assign s_axis.tready = (state == S_RECV) && !aresetn;
    assign m_axis.tvalid = (state == S_SEND || state == S_SUM) && !aresetn;
    assign m_axis.tlast  = (state == S_SUM) && !aresetn;
    assign m_axis.tdata  = m_data;

    assign in_fire   = s_axis.tvalid && s_axis.tready;
    assign out_fire  = m_axis.tvalid && m_axis.tready;
    assign store     = in_fire && (count < CW'(DEPTH));
    assign last_word = ({1'b0, rd_ptr} == (count - CW'(1)));

    always_comb begin
        m_data = '0;
        if (!aresetn) begin
            if (state == S_SEND)
                m_data = OUT_WIDTH'($signed(rd_q));
            else if (state == S_SUM)
                m_data = sum;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        case (state)
            S_INIT: state_nxt = S_RECV;
            S_RECV: if (in_fire && s_axis.tlast) state_nxt = S_LOAD;
            S_LOAD: begin
                rd_ptr_nxt = '0;
                state_nxt  = (count == '0) ? S_SUM : S_SEND;
            end
            S_SEND: begin
                if (out_fire) begin
                    if (last_word)
                        state_nxt = S_SUM;
                    else
                        rd_ptr_nxt = rd_ptr + AW'(1);
                end
            end
            S_SUM:  if (out_fire) state_nxt = S_RECV;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state  <= S_INIT;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn || (state == S_SUM && out_fire)) begin
            count <= '0;
            sum   <= '0;
        end else if (store) begin
            count <= count + CW'(1);
            sum   <= sum + OUT_WIDTH'($signed(s_axis.tdata));
        end
    end

    // Read address follows the pointer it is about to become, so a stalled word
    // is simply re-read and stays stable without a separate skid register.
    always_ff @(posedge aclk) begin
        if (store)
            mem[count[AW-1:0]] <= s_axis.tdata;
        rd_q <= mem[rd_ptr_nxt];
    end
endmodule

// File: tb/tb_io_dma.sv
// Randomized bench for io_dma against a queue-based frame model with per-cycle output checks.
module tb_io_dma;
    localparam int DEPTH = 1024;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;

    io_dma_if #(.WIDTH(20)) s_if ();
    io_dma_if #(.WIDTH(32)) m_if ();

    io_dma #(.IN_WIDTH(20), .OUT_WIDTH(32), .DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axis  (s_if),
        .m_axis  (m_if)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] mbuf[$];
    logic [31:0] msum;
    int          mcount;
    bit          busy, first_seen, stalled, after_rst;
    int          lat;
    logic [31:0] held_d;
    logic        held_l;
    logic [31:0] ed;
    bit          el;
    int          frame_out, frame_words;
    logic [31:0] last_cksum;
    logic [31:0] out_log[$];
    int          bp_mode;
    logic [19:0] fr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [19:0] v);
        return {{12{v[19]}}, v};
    endfunction

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1 m_if.tready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            chk("rst_s_tready", 32'(s_if.tready), 0);
            chk("rst_m_tvalid", 32'(m_if.tvalid), 0);
            chk("rst_m_tdata", m_if.tdata, 0);
            chk("rst_m_tlast", 32'(m_if.tlast), 0);
            exp_d.delete(); exp_l.delete(); mbuf.delete();
            msum = '0; mcount = 0; busy = 0; first_seen = 0; stalled = 0;
            lat = 0; frame_out = 0; after_rst = 1;
        end else if (after_rst) begin
            chk("post_rst_s_tready", 32'(s_if.tready), 0);
            chk("post_rst_m_tvalid", 32'(m_if.tvalid), 0);
            chk("post_rst_m_tdata", m_if.tdata, 0);
            chk("post_rst_m_tlast", 32'(m_if.tlast), 0);
            after_rst = 0;
        end else begin
            chk("s_tready", 32'(s_if.tready), busy ? 32'd0 : 32'd1);
            if (!busy) begin
                chk("m_tvalid_idle", 32'(m_if.tvalid), 0);
            end else begin
                if (!first_seen) begin
                    lat++;
                    if (lat >= 3) chk("first_valid_latency", 32'(m_if.tvalid), 1);
                    if (m_if.tvalid) first_seen = 1;
                end else begin
                    chk("m_tvalid_no_gap", 32'(m_if.tvalid), 1);
                end
                if (m_if.tvalid) begin
                    if (stalled) begin
                        chk("stall_data", m_if.tdata, held_d);
                        chk("stall_last", 32'(m_if.tlast), 32'(held_l));
                    end
                    if (m_if.tready) begin
                        stalled = 0;
                        if (exp_d.size() == 0) begin
                            chk("unexpected_word", 32'(m_if.tvalid), 0);
                        end else begin
                            ed = exp_d.pop_front();
                            el = exp_l.pop_front();
                            chk("out_data", m_if.tdata, ed);
                            chk("out_last", 32'(m_if.tlast), 32'(el));
                            out_log.push_back(m_if.tdata);
                            frame_out++;
                            if (el) begin
                                busy = 0; first_seen = 0; lat = 0;
                                last_cksum = m_if.tdata;
                                frame_words = frame_out;
                                frame_out = 0;
                            end
                        end
                    end else begin
                        stalled = 1;
                        held_d  = m_if.tdata;
                        held_l  = m_if.tlast;
                    end
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                if (mcount < DEPTH) begin
                    mbuf.push_back(sx(s_if.tdata));
                    msum = msum + sx(s_if.tdata);
                    mcount++;
                end
                if (s_if.tlast) begin
                    foreach (mbuf[i]) begin
                        exp_d.push_back(mbuf[i]);
                        exp_l.push_back(1'b0);
                    end
                    exp_d.push_back(msum);
                    exp_l.push_back(1'b1);
                    mbuf.delete(); msum = '0; mcount = 0; busy = 1;
                end
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        @(negedge aclk);
        while (!s_if.tready && t < 5000) begin
            t++;
            @(negedge aclk);
        end
        if (t >= 5000) chk("accept_timeout", 32'(s_if.tready), 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_if.tvalid = 1'b0;
                    @(posedge aclk);
                    #1;
                end
            end
            s_if.tdata  = fr[i];
            s_if.tlast  = (i == fr.size() - 1);
            s_if.tvalid = 1'b1;
            wait_accept();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 20000) begin
            @(posedge aclk);
            t++;
        end
        #1;
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic fill_random(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(20'($urandom));
    endtask

    initial begin
        int n;
        int t;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        bp_mode     = 0;
        aresetn     = 1'b1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        fr.delete();
        for (int i = 0; i < 786; i++) fr.push_back(20'(i));
        out_log.delete();
        send_frame(0);
        wait_idle();
        chk("cksum_786", last_cksum, 32'h0004B519);
        chk("words_786", 32'(frame_words), 787);
        chk("first_786", out_log[0], 0);
        chk("lastdata_786", out_log[785], 785);

        fr.delete();
        fr.push_back(20'hFFFFF); fr.push_back(20'h80000); fr.push_back(20'h00001);
        out_log.delete();
        send_frame(0);
        wait_idle();
        chk("neg_0", out_log[0], 32'hFFFFFFFF);
        chk("neg_1", out_log[1], 32'hFFF80000);
        chk("neg_2", out_log[2], 32'h00000001);
        chk("neg_cksum", out_log[3], 32'hFFF80000);
        chk("neg_words", 32'(frame_words), 4);

        bp_mode = 1;
        fill_random(10);
        send_frame(0);
        wait_idle();
        chk("bp_words", 32'(frame_words), 11);

        bp_mode = 0;
        fr.delete();
        fr.push_back(20'h00005);
        out_log.delete();
        send_frame(0);
        wait_idle();
        chk("single_data", out_log[0], 32'h00000005);
        chk("single_cksum", out_log[1], 32'h00000005);

        bp_mode = 1;
        repeat (6) begin
            n = $urandom_range(1, 40);
            fill_random(n);
            send_frame(1);
            wait_idle();
            chk("rand_words", 32'(frame_words), 32'(n + 1));
        end

        fill_random(1030);
        send_frame(0);
        wait_idle();
        chk("overflow_words", 32'(frame_words), 1025);

        bp_mode = 0;
        fill_random(10);
        send_frame(0);
        t = 0;
        while (frame_out < 3 && t < 100) begin
            @(posedge aclk);
            #1;
            t++;
        end
        chk("midsend_progress", 32'(frame_out >= 3), 1);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        fr.delete();
        fr.push_back(20'd7); fr.push_back(20'd8);
        out_log.delete();
        send_frame(0);
        wait_idle();
        chk("post_rst_0", out_log[0], 32'd7);
        chk("post_rst_1", out_log[1], 32'd8);
        chk("post_rst_cksum", out_log[2], 32'd15);
        chk("post_rst_words", 32'(frame_words), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
